spi_master: RTL and testbench

- Single-byte SPI master: one byte in on a valid/ready handshake, transmitted on MOSI while one byte is captured from MISO, received byte returned with a one-cycle strobe.
- Drives SCLK, MOSI and the active-low slave select (SS) for one peripheral in any of the four SPI modes.
- The SPI side of the FPGA system bus: it starts every transaction.

---
 rtl/spi_master.sv | 135 +++++++++++++
 tb/tb_spi_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Single-byte SPI master (all four modes, MSB/LSB first) with valid/ready byte intake and rx strobe.
// Latency: SS falls 1 cycle after accept, rx strobe at 1+17N, ready again at 1+18N (N = CLKS_PER_HALF_BIT).
// Backpressure: o_tx_ready is low for the whole frame and inter-frame gap; offers made while busy are dropped.
module spi_master #(
    parameter int MODE              = 0,
    parameter int FRAME_FORMAT      = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic       o_ss
);

    localparam logic CPOL      = MODE[1];
    localparam logic CPHA      = MODE[0];
    localparam logic LSB_FIRST = (FRAME_FORMAT == 1);
    localparam int   HB_W      = (CLKS_PER_HALF_BIT < 2) ? 1 : $clog2(CLKS_PER_HALF_BIT);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(CLKS_PER_HALF_BIT - 1);

    generate
        if (CLKS_PER_HALF_BIT < 2 || MODE < 0 || MODE > 3 || FRAME_FORMAT < 0 || FRAME_FORMAT > 1) begin : g_bad_param
            $error("spi_master: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t            state;
    logic [HB_W-1:0]   hb_cnt;
    logic [4:0]        edge_cnt;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;

    logic       hb_wrap;
    logic [4:0] edge_nxt;
    logic       lead_edge;
    logic       sample_now;
    logic       shift_now;

    assign hb_wrap    = (hb_cnt == HB_LAST);
    assign edge_nxt   = edge_cnt + 5'd1;
    assign lead_edge  = edge_nxt[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges; MOSI moves on the other one.
    assign sample_now = lead_edge ^ CPHA;
    assign shift_now  = CPHA ? (lead_edge && (edge_nxt != 5'd1))
                             : (!lead_edge && (edge_nxt != 5'd16));
    assign o_tx_ready = !o_busy;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state      <= S_IDLE;
            hb_cnt     <= '0;
            edge_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            o_ss       <= 1'b1;
            o_sclk     <= CPOL;
            o_mosi     <= 1'b0;
            o_busy     <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_byte  <= '0;
        end else begin
            o_rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_tx_valid) begin
                        tx_sh    <= i_tx_byte;
                        o_mosi   <= LSB_FIRST ? i_tx_byte[0] : i_tx_byte[7];
                        o_ss     <= 1'b0;
                        o_busy   <= 1'b1;
                        hb_cnt   <= '0;
                        edge_cnt <= '0;
                        state    <= S_LEAD;
                    end
                end
                S_LEAD, S_XFER: begin
                    if (hb_wrap) begin
                        hb_cnt   <= '0;
                        edge_cnt <= edge_nxt;
                        o_sclk   <= ~o_sclk;
                        state    <= (edge_nxt == 5'd16) ? S_TRAIL : S_XFER;
                        if (sample_now) begin
                            rx_sh <= LSB_FIRST ? {i_miso, rx_sh[7:1]} : {rx_sh[6:0], i_miso};
                        end
                        if (shift_now) begin
                            tx_sh  <= LSB_FIRST ? (tx_sh >> 1) : (tx_sh << 1);
                            o_mosi <= LSB_FIRST ? tx_sh[1] : tx_sh[6];
                        end
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (hb_wrap) begin
                        hb_cnt     <= '0;
                        o_ss       <= 1'b1;
                        o_mosi     <= 1'b0;
                        o_rx_byte  <= rx_sh;
                        o_rx_valid <= 1'b1;
                        state      <= S_GAP;
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(1);
                    end
                end
                S_GAP: begin
                    if (hb_wrap) begin
                        hb_cnt   <= '0;
                        edge_cnt <= '0;
                        o_busy   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Five spi_master instances (different mode / bit order / N) checked every cycle against a
// timing model that derives each output from the cycle count since accept.
module tb_spi_master;

    localparam int NI = 5;

    function automatic int p_mode(input int i);
        case (i)
            0: return 0;
            1: return 3;
            2: return 1;
            3: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int p_lsb(input int i);
        return (i == 1 || i == 4) ? 1 : 0;
    endfunction

    function automatic int p_n(input int i);
        case (i)
            0: return 2;
            1: return 4;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    logic          w_Clk;
    logic          w_Rst_n;
    logic [NI-1:0] tx_valid, tx_ready, rx_valid, busy, sclk, mosi, miso, ss;
    logic [7:0]    tx_byte [NI];
    logic [7:0]    rx_byte [NI];

    initial w_Clk = 1'b0;
    always #5 w_Clk = ~w_Clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            spi_master #(
                .MODE(p_mode(g)),
                .FRAME_FORMAT(p_lsb(g)),
                .CLKS_PER_HALF_BIT(p_n(g))
            ) u_dut (
                .i_Clk(w_Clk),
                .i_Rst_n(w_Rst_n),
                .i_tx_valid(tx_valid[g]),
                .i_tx_byte(tx_byte[g]),
                .o_tx_ready(tx_ready[g]),
                .o_rx_byte(rx_byte[g]),
                .o_rx_valid(rx_valid[g]),
                .o_busy(busy[g]),
                .o_sclk(sclk[g]),
                .o_mosi(mosi[g]),
                .i_miso(miso[g]),
                .o_ss(ss[g])
            );
        end
    endgenerate

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit armed = 0;
    bit rst_prev = 0;

    // model state
    bit         act [NI];
    int         acc [NI];
    logic [7:0] txb [NI];
    logic [7:0] exp_rx [NI];
    bit         rb [NI][8];
    int         rcnt [NI];
    // slave-side observations
    bit         slave_en [NI];
    logic [7:0] slave_b [NI];
    logic [7:0] dec [NI];
    logic [7:0] sent_last [NI];
    logic [7:0] sent_prev [NI];
    int         dcnt [NI];
    int         run [NI];
    int         ss_lo_len [NI];
    int         ss_hi_len [NI];
    int         rdy_ret [NI];
    int         rxv_cnt [NI];
    logic       p_ss [NI];
    logic       p_sclk [NI];
    logic       p_mosi [NI];
    logic       p_busy [NI];

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, i, cyc, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx, input int lsb);
        logic [7:0] v;
        v = b;
        return (lsb != 0) ? v[idx] : v[7 - idx];
    endfunction

    // Which data bit is on the wire t cycles after accept (same rule for master MOSI and slave MISO).
    function automatic int bit_idx(input int t, input int n, input int cpha);
        int e;
        int r;
        e = (t - 1) / n;
        if (e > 16) e = 16;
        if (cpha == 0) r = e / 2;
        else r = (e == 0) ? 0 : (e - 1) / 2;
        if (r > 7) r = 7;
        return r;
    endfunction

    function automatic bit any_act();
        for (int i = 0; i < NI; i++) if (act[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic monitor_step();
        for (int i = 0; i < NI; i++) begin
            int n, cpha, lsb, t, e;
            logic cpol, e_ss, e_sclk, e_mosi, e_busy, e_rxv, leading;
            bit was_act;
            logic [7:0] r;
            n = p_n(i);
            cpha = p_mode(i) % 2;
            cpol = logic'(p_mode(i) / 2);
            lsb = p_lsb(i);
            was_act = act[i];
            t = cyc - acc[i];
            if (act[i] && t > 18 * n) act[i] = 0;

            e_ss = 1; e_sclk = cpol; e_mosi = 0; e_busy = 0; e_rxv = 0;
            if (act[i]) begin
                if (t == 1 + 17 * n) begin
                    r = '0;
                    for (int j = 0; j < 8; j++) begin
                        if (lsb != 0) r[j] = rb[i][j];
                        else r[7 - j] = rb[i][j];
                    end
                    exp_rx[i] = r;
                end
                e = (t - 1) / n;
                if (e > 16) e = 16;
                e_ss   = (t <= 17 * n) ? 1'b0 : 1'b1;
                e_sclk = cpol ^ logic'(e % 2);
                e_mosi = e_ss ? 1'b0 : frame_bit(txb[i], bit_idx(t, n, cpha), lsb);
                e_busy = 1'b1;
                e_rxv  = (t == 1 + 17 * n);
            end
            chk("ss", i, ss[i], e_ss);
            chk("sclk", i, sclk[i], e_sclk);
            chk("mosi", i, mosi[i], e_mosi);
            chk("busy", i, busy[i], e_busy);
            chk("ready", i, tx_ready[i], !e_busy);
            chk("rx_valid", i, rx_valid[i], e_rxv);
            chk("rx_byte", i, rx_byte[i], exp_rx[i]);

            // slave view: latch MOSI on the sampling edge of the mode
            if (!p_ss[i] && sclk[i] != p_sclk[i]) begin
                leading = (sclk[i] != cpol);
                if (leading == (cpha == 0)) begin
                    dec[i] = (lsb != 0) ? {p_mosi[i], dec[i][7:1]} : {dec[i][6:0], p_mosi[i]};
                    dcnt[i]++;
                end
            end
            if (ss[i] != p_ss[i]) begin
                if (!p_ss[i]) begin
                    ss_lo_len[i] = run[i];
                    if (!rst_prev) begin
                        chk("frame_bits", i, dcnt[i], 8);
                        sent_prev[i] = sent_last[i];
                        sent_last[i] = dec[i];
                    end
                end else begin
                    ss_hi_len[i] = run[i];
                    dcnt[i] = 0;
                end
                run[i] = 1;
            end else begin
                run[i]++;
            end
            if (was_act && p_busy[i] && !busy[i]) rdy_ret[i] = t;
            if (rx_valid[i]) rxv_cnt[i]++;

            if (act[i] && w_Rst_n && (t % n) == 0) begin
                e = t / n;
                if (e >= 1 && e <= 16 && ((e % 2 == 1) == (cpha == 0)) && rcnt[i] < 8) begin
                    rb[i][rcnt[i]] = miso[i];
                    rcnt[i]++;
                end
            end
            if (!act[i] && w_Rst_n && tx_valid[i]) begin
                act[i] = 1;
                acc[i] = cyc;
                txb[i] = tx_byte[i];
                rcnt[i] = 0;
            end
            if (!w_Rst_n) begin
                act[i] = 0;
                exp_rx[i] = '0;
            end
            p_ss[i] = ss[i];
            p_sclk[i] = sclk[i];
            p_mosi[i] = mosi[i];
            p_busy[i] = busy[i];
        end
        rst_prev = !w_Rst_n;
    endtask

    task automatic tick();
        @(posedge w_Clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (((busy != '0) || any_act()) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
        end
        tick();
    endtask

    task automatic go(input logic [NI-1:0] mask);
        tx_valid = mask;
        tick();
        tx_valid = '0;
        wait_idle(300);
    endtask

    initial begin
        w_Rst_n = 1'b0;
        tx_valid = '0;
        miso = '0;
        for (int i = 0; i < NI; i++) begin
            tx_byte[i] = '0;
            slave_en[i] = 0;
            slave_b[i] = '0;
        end

        fork
            forever begin
                @(posedge w_Clk);
                cyc++;
                #1;
                for (int i = 0; i < NI; i++) begin
                    int t;
                    t = cyc - acc[i];
                    if (act[i] && slave_en[i] && t >= 1 && t <= 18 * p_n(i))
                        miso[i] = frame_bit(slave_b[i], bit_idx(t, p_n(i), p_mode(i) % 2), p_lsb(i));
                    else
                        miso[i] = logic'($urandom % 2);
                end
            end
            forever begin
                @(negedge w_Clk);
                if (armed) begin
                    monitor_step();
                end else if (!w_Rst_n) begin
                    armed = 1;
                    rst_prev = 1;
                    for (int i = 0; i < NI; i++) begin
                        act[i] = 0; exp_rx[i] = '0; rcnt[i] = 0; dcnt[i] = 0; run[i] = 0;
                        rxv_cnt[i] = 0; rdy_ret[i] = 0; dec[i] = '0;
                        sent_last[i] = '0; sent_prev[i] = '0;
                        p_ss[i] = 1'b1; p_sclk[i] = logic'(p_mode(i) / 2); p_mosi[i] = 1'b0; p_busy[i] = 1'b0;
                    end
                end
            end
        join_none

        repeat (3) tick();
        w_Rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_ss", i, ss[i], 1);
            chk("rst_sclk", i, sclk[i], p_mode(i) / 2);
            chk("rst_rx_byte", i, rx_byte[i], 8'h00);
        end

        // directed frames, all instances at once
        tx_byte[0] = 8'hA5; slave_b[0] = 8'h3C; slave_en[0] = 1;
        tx_byte[1] = 8'h81; slave_b[1] = 8'h7E; slave_en[1] = 1;
        tx_byte[2] = 8'hF0; slave_b[2] = 8'h0F; slave_en[2] = 1;
        tx_byte[3] = 8'hF0; slave_b[3] = 8'h0F; slave_en[3] = 1;
        tx_byte[4] = 8'($urandom); slave_en[4] = 0;
        go(5'b11111);
        chk("rx_lit", 0, rx_byte[0], 8'h3C);
        chk("mosi_lit", 0, sent_last[0], 8'hA5);
        chk("ss_low_len", 0, ss_lo_len[0], 34);
        chk("ready_ret", 0, rdy_ret[0], 37);
        chk("rxv_pulses", 0, rxv_cnt[0], 1);
        chk("rx_lit", 1, rx_byte[1], 8'h7E);
        chk("mosi_lit", 1, sent_last[1], 8'h81);
        chk("sclk_idle_hi", 1, sclk[1], 1);
        chk("rx_lit", 2, rx_byte[2], 8'h0F);
        chk("mosi_lit", 2, sent_last[2], 8'hF0);
        chk("rx_lit", 3, rx_byte[3], 8'h0F);
        chk("mosi_lit", 3, sent_last[3], 8'hF0);

        // back-to-back with valid held; 0x33 offered only while busy
        slave_en[0] = 0;
        tx_byte[0] = 8'h11;
        tx_valid[0] = 1'b1;
        tick();
        tx_byte[0] = 8'h33;
        repeat (36) tick();
        tx_byte[0] = 8'h22;
        tick();
        tx_byte[0] = 8'h33;
        repeat (35) tick();
        tx_valid[0] = 1'b0;
        wait_idle(300);
        chk("b2b_first", 0, sent_prev[0], 8'h11);
        chk("b2b_second", 0, sent_last[0], 8'h22);
        chk("b2b_pulses", 0, rxv_cnt[0], 3);
        chk("b2b_ss_gap", 0, ss_hi_len[0], 3);

        // reset in the middle of a frame, around SCLK edge 7
        tx_byte[0] = 8'hC3;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        repeat (13) tick();
        w_Rst_n = 1'b0;
        tick();
        w_Rst_n = 1'b1;
        chk("abort_ss", 0, ss[0], 1);
        chk("abort_sclk", 0, sclk[0], 0);
        chk("abort_busy", 0, busy[0], 0);
        chk("abort_rx_valid", 0, rx_valid[0], 0);
        chk("abort_rx_byte", 0, rx_byte[0], 8'h00);
        tick();
        tx_byte[0] = 8'h5A; slave_b[0] = 8'hA6; slave_en[0] = 1;
        go(5'b00001);
        chk("post_abort_rx", 0, rx_byte[0], 8'hA6);
        chk("post_abort_mosi", 0, sent_last[0], 8'h5A);
        chk("post_abort_pulses", 0, rxv_cnt[0], 4);

        // randomized frames on random subsets of instances
        repeat (25) begin
            logic [NI-1:0] mask;
            for (int i = 0; i < NI; i++) begin
                tx_byte[i] = 8'($urandom);
                slave_b[i] = 8'($urandom);
                slave_en[i] = bit'($urandom % 2);
            end
            mask = NI'($urandom);
            if (mask == '0) mask = 5'b10000;
            go(mask);
            repeat ($urandom % 4) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
